// File: rtl/lexer_pkg.sv
// Shared lexer definitions: token kinds, character classes and FSM states.
// Token kinds match the columns of the parser's action table.
package lexer_pkg;
    localparam int TOK_W = 16;
    typedef logic [TOK_W-1:0] token_t;

    // All kinds stay below 16 so they index the 16-column action table
    localparam logic [7:0] K_EOF    = 8'h00;
    localparam logic [7:0] K_NUM    = 8'h01;
    localparam logic [7:0] K_PLUS   = 8'h02;
    localparam logic [7:0] K_MINUS  = 8'h03;
    localparam logic [7:0] K_STAR   = 8'h04;
    localparam logic [7:0] K_SLASH  = 8'h05;
    localparam logic [7:0] K_LPAREN = 8'h06;
    localparam logic [7:0] K_RPAREN = 8'h07;
    localparam logic [7:0] K_ERR    = 8'h0F;

    localparam logic [7:0] CH_EOF = 8'h00;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    typedef enum logic [1:0] {S_IDLE, S_NUM, S_DONE, S_ERR} state_t;

    // Returns K_EOF for anything that is not an operator or parenthesis
    function automatic logic [7:0] op_kind(input logic [7:0] c);
        case (c)
            8'h2B:   return K_PLUS;
            8'h2D:   return K_MINUS;
            8'h2A:   return K_STAR;
            8'h2F:   return K_SLASH;
            8'h28:   return K_LPAREN;
            8'h29:   return K_RPAREN;
            default: return K_EOF;
        endcase
    endfunction

    function automatic logic is_space(input logic [7:0] c);
        return (c == CH_SP) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
    endfunction
endpackage

// File: rtl/lexer_if.sv
// Character input and token output handshakes of the lexer.
interface lexer_if;
    import lexer_pkg::*;

    logic       I_VALID;
    logic [7:0] I_CHAR;
    logic       O_READY;
    logic       I_RECEIVE;
    logic       O_VALID;
    token_t     O_TOKEN;
    logic [1:0] STAT;

    modport master (input I_VALID, I_CHAR, I_RECEIVE,
                    output O_READY, O_VALID, O_TOKEN, STAT);
    modport slave  (output I_VALID, I_CHAR, I_RECEIVE,
                    input O_READY, O_VALID, O_TOKEN, STAT);
endinterface

// File: rtl/lexer_token_fifo_16.sv
// Token FIFO with two write ports (one character can produce two tokens)
// and a single read port; head reads as zero when empty.
module token_fifo_16 import lexer_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push0,
    input  logic          push1,
    input  token_t        data0,
    input  token_t        data1,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          empty,
    output token_t        head
);
    token_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;

    assign wr_ptr1 = wr_ptr + AW'(1);
    assign empty   = (count == '0);
    assign head    = empty ? '0 : mem[rd_ptr];

    // push1 is only ever raised together with push0, so it lands one slot later
    always_ff @(posedge CLK) begin
        if (push0) mem[wr_ptr]  <= data0;
        if (push1) mem[wr_ptr1] <= data1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end
endmodule

// File: rtl/lexer.sv
// Byte-stream tokenizer feeding the LR parser: digits fold into NUM tokens,
// operators/parens map to kinds, whitespace is skipped.
module lexer import lexer_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    lexer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    logic [7:0]    acc;
    logic          ready, done, error;
    logic [CW-1:0] count;
    logic          empty;
    token_t        head;

    logic       accept, pop, is_digit, is_ws, is_eof, is_op, char_tok, stops;
    logic       push0, push1;
    token_t     data0, data1, tok_char;
    logic [7:0] kind_op;
    int         count_nxt;

    always_comb begin
        kind_op  = op_kind(bus.I_CHAR);
        is_digit = (bus.I_CHAR >= CH_0) && (bus.I_CHAR <= CH_9);
        is_ws    = is_space(bus.I_CHAR);
        is_eof   = (bus.I_CHAR == CH_EOF);
        is_op    = (kind_op != K_EOF);
        accept   = bus.I_VALID && ready;
        pop      = bus.I_RECEIVE && !empty;
        char_tok = !is_digit && !is_ws;
        stops    = accept && char_tok && !is_op;

        if (is_eof)     tok_char = {K_EOF, 8'h00};
        else if (is_op) tok_char = {kind_op, 8'h00};
        else            tok_char = {K_ERR, bus.I_CHAR};

        push0 = 1'b0;
        push1 = 1'b0;
        data0 = tok_char;
        data1 = tok_char;
        if (accept && state == S_NUM) begin
            // Any non-digit closes the number; its own token follows in slot 1
            push0 = !is_digit;
            data0 = {K_NUM, acc};
            push1 = char_tok;
        end else if (accept && state == S_IDLE) begin
            push0 = char_tok;
        end

        count_nxt = int'(count) + int'(push0) + int'(push1) - int'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            acc   <= '0;
            ready <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            if (accept) begin
                if (is_digit) begin
                    acc   <= (state == S_NUM ? acc * 8'd10 : 8'd0) + {4'h0, bus.I_CHAR[3:0]};
                    state <= S_NUM;
                end else if (is_eof) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else if (is_op || is_ws) begin
                    state <= S_IDLE;
                end else begin
                    state <= S_ERR;
                    error <= 1'b1;
                end
            end
            // Keep two free slots: the next character may push two tokens
            ready <= (state == S_IDLE || state == S_NUM) && !stops
                     && (count_nxt <= FIFO_DEPTH - 2);
        end
    end

    token_fifo_16 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push0 (push0),
        .push1 (push1),
        .data0 (data0),
        .data1 (data1),
        .pop   (pop),
        .count (count),
        .empty (empty),
        .head  (head)
    );

    assign bus.O_READY = ready;
    assign bus.O_VALID = !empty;
    assign bus.O_TOKEN = head;
    assign bus.STAT    = {done, error};
endmodule

// File: tb/tb_lexer.sv
// Directed bench for the lexer: table of source strings with expected token
// streams, plus backpressure and mid-number reset sequences.
module tb_lexer;
    logic CLK, RST;
    lexer_if bus ();

    lexer #(.FIFO_DEPTH(4)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        string       chars;    // '@' stands for the 0x00 end-of-input byte
        int          rmode;    // 0: never receive, 1: receive when valid, 2: receive held high
        int          nacc;
        int          nexp;
        logic [15:0] exp [8];
        logic [1:0]  stat;
    } vec_t;

    vec_t vt [6];

    int          napplied = 0;
    int          nmis = 0;
    byte         src [$];
    logic [15:0] got [$];
    int          idx;
    logic        drv_prev, rdy_prev, rcv_prev, vld_prev;
    logic [15:0] tok_prev;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        napplied++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input string s);
        src.delete();
        for (int i = 0; i < s.len(); i++) src.push_back(s[i] == "@" ? 8'h00 : s[i]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.I_VALID = 1'b0;
        bus.I_CHAR = 8'h00;
        bus.I_RECEIVE = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst O_VALID", {15'h0, bus.O_VALID}, 16'h0);
        chk("rst O_TOKEN", bus.O_TOKEN, 16'h0000);
        chk("rst O_READY", {15'h0, bus.O_READY}, 16'h0);
        chk("rst STAT", {14'h0, bus.STAT}, 16'h0);
        RST = 1'b0;
        {drv_prev, rdy_prev, rcv_prev, vld_prev} = '0;
        tok_prev = '0;
        idx = 0;
        got.delete();
    endtask

    // One cycle: account for last edge's handshakes, then drive the next
    task automatic step(input int rmode);
        @(negedge CLK);
        if (drv_prev && rdy_prev) idx++;
        if (rcv_prev && vld_prev) got.push_back(tok_prev);
        bus.I_VALID   = (idx < src.size());
        bus.I_CHAR    = (idx < src.size()) ? src[idx] : 8'h00;
        bus.I_RECEIVE = (rmode == 2) || (rmode == 1 && bus.O_VALID);
        drv_prev = bus.I_VALID;
        rdy_prev = bus.O_READY;
        rcv_prev = bus.I_RECEIVE;
        vld_prev = bus.O_VALID;
        tok_prev = bus.O_TOKEN;
    endtask

    task automatic check_stream(input string name, input int nexp, input logic [15:0] exp [8]);
        chk({name, " count"}, 16'(got.size()), 16'(nexp));
        for (int i = 0; i < nexp; i++)
            chk($sformatf("%s tok%0d", name, i), (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
    endtask

    initial begin
        logic [15:0] bp_exp [8];
        logic [15:0] rs_exp [8];

        vt[0] = '{"12+3",   "12+3@4",           1, 5, 4,
                  '{16'h010C, 16'h0200, 16'h0103, 16'h0000, 0, 0, 0, 0}, 2'b10};
        vt[1] = '{"300",    "300@",             1, 4, 2,
                  '{16'h012C, 16'h0000, 0, 0, 0, 0, 0, 0}, 2'b10};
        vt[2] = '{"parens", " (\t7\r)\n@",      1, 8, 4,
                  '{16'h0600, 16'h0107, 16'h0700, 16'h0000, 0, 0, 0, 0}, 2'b10};
        vt[3] = '{"err",    "5#7",              1, 2, 2,
                  '{16'h0105, 16'h0F23, 0, 0, 0, 0, 0, 0}, 2'b01};
        vt[4] = '{"mixed",  "255 1-0/9*@",      2, 11, 8,
                  '{16'h01FF, 16'h0101, 16'h0300, 16'h0100, 16'h0500, 16'h0109, 16'h0400, 16'h0000}, 2'b10};
        vt[5] = '{"256",    "256@",             1, 4, 2,
                  '{16'h0100, 16'h0000, 0, 0, 0, 0, 0, 0}, 2'b10};

        RST = 1'b1;
        bus.I_VALID = 1'b0;
        bus.I_CHAR = 8'h00;
        bus.I_RECEIVE = 1'b0;

        foreach (vt[k]) begin
            do_reset();
            load(vt[k].chars);
            repeat (60) step(vt[k].rmode);
            check_stream(vt[k].name, vt[k].nexp, vt[k].exp);
            chk({vt[k].name, " accepted"}, 16'(idx), 16'(vt[k].nacc));
            chk({vt[k].name, " STAT"}, {14'h0, bus.STAT}, {14'h0, vt[k].stat});
            chk({vt[k].name, " O_READY"}, {15'h0, bus.O_READY}, 16'h0);
            chk({vt[k].name, " drained"}, {15'h0, bus.O_VALID}, 16'h0);
        end

        // Backpressure: parser stalls, FIFO fills, head must hold
        do_reset();
        load("1+2+3+4@");
        repeat (15) step(0);
        chk("bp accepted", 16'(idx), 16'd4);
        chk("bp O_READY", {15'h0, bus.O_READY}, 16'h0);
        chk("bp O_VALID", {15'h0, bus.O_VALID}, 16'h1);
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk($sformatf("bp hold%0d", i), bus.O_TOKEN, 16'h0101);
        end
        repeat (60) step(1);
        bp_exp = '{16'h0101, 16'h0200, 16'h0102, 16'h0200, 16'h0103, 16'h0200, 16'h0104, 16'h0000};
        check_stream("bp", 8, bp_exp);
        chk("bp STAT", {14'h0, bus.STAT}, 16'h2);

        // Reset in the middle of a number discards the partial value
        do_reset();
        load("98");
        repeat (6) step(1);
        chk("98 accepted", 16'(idx), 16'd2);
        chk("98 pending", {15'h0, bus.O_VALID}, 16'h0);
        do_reset();
        load("4@");
        repeat (20) step(1);
        rs_exp = '{16'h0104, 16'h0000, 0, 0, 0, 0, 0, 0};
        check_stream("rst-mid", 2, rs_exp);
        chk("rst-mid STAT", {14'h0, bus.STAT}, 16'h2);

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
        $finish;
    end
endmodule
